// File: rtl/tdm_demux_1x4_if.sv
// TDM demux bus: serial word stream in, four channel registers plus status out.
interface tdm_demux_1x4_if #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8
);
  logic [WIDTH-1:0]   DIN;
  logic               DIN_VLD;
  logic               SOF;
  logic [4*WIDTH-1:0] F;
  logic [3:0]         F_VLD;
  logic               FRAME_DONE;
  logic               LOCKED;
  logic               SYNC_ERR;
  logic [ERRW-1:0]    ERR_CNT;

  modport slave (
    input  DIN, DIN_VLD, SOF,
    output F, F_VLD, FRAME_DONE, LOCKED, SYNC_ERR, ERR_CNT
  );
  modport master (
    output DIN, DIN_VLD, SOF,
    input  F, F_VLD, FRAME_DONE, LOCKED, SYNC_ERR, ERR_CNT
  );
endinterface

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer with SOF-based frame alignment, sync-error detection
// and a saturating error counter. All outputs registered, one cycle latency.
module tdm_demux_1x4 #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8
) (
  input  logic           CLK,
  input  logic           RST,
  tdm_demux_1x4_if.slave bus
);
  typedef enum logic {HUNT, LOCK} state_t;

  state_t             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [4*WIDTH-1:0] f_q, f_d;
  logic [3:0]         fvld_q, fvld_d;
  logic               done_q, done_d;
  logic               serr_q, serr_d;
  logic [ERRW-1:0]    ecnt_q, ecnt_d;
  logic               wr;
  logic [1:0]         wr_slot;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HUNT;
      slot_q  <= '0;
      f_q     <= '0;
      fvld_q  <= '0;
      done_q  <= 1'b0;
      serr_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      f_q     <= f_d;
      fvld_q  <= fvld_d;
      done_q  <= done_d;
      serr_q  <= serr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    f_d     = f_q;
    fvld_d  = '0;
    done_d  = 1'b0;
    serr_d  = 1'b0;
    wr      = 1'b0;
    wr_slot = 2'd0;
    if (bus.DIN_VLD) begin
      case (state_q)
        HUNT: begin
          if (bus.SOF) begin
            wr      = 1'b1;
            slot_d  = 2'd1;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (bus.SOF) begin
            // An early SOF restarts the frame on this word rather than dropping lock.
            wr     = 1'b1;
            slot_d = 2'd1;
            serr_d = (slot_q != 2'd0);
          end else if (slot_q != 2'd0) begin
            wr      = 1'b1;
            wr_slot = slot_q;
            slot_d  = slot_q + 2'd1;
            done_d  = (slot_q == 2'd3);
          end else begin
            serr_d  = 1'b1;
            state_d = HUNT;
            slot_d  = 2'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      if (wr && wr_slot == 2'(i)) begin
        f_d[i*WIDTH +: WIDTH] = bus.DIN;
        fvld_d[i]             = 1'b1;
      end
    end
    ecnt_d = (serr_d && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
  end

  assign bus.F          = f_q;
  assign bus.F_VLD      = fvld_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.LOCKED     = (state_q == LOCK);
  assign bus.SYNC_ERR   = serr_q;
  assign bus.ERR_CNT    = ecnt_q;
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed bench: two instances (ERRW=8 and ERRW=2) driven with identical stimulus.
`timescale 1ns/1ps
module tb_tdm_demux_1x4;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  tdm_demux_1x4_if #(.WIDTH(8), .ERRW(8)) bus  ();
  tdm_demux_1x4_if #(.WIDTH(8), .ERRW(2)) bus2 ();

  tdm_demux_1x4 #(.WIDTH(8), .ERRW(8)) u_dut  (.CLK(CLK), .RST(RST), .bus(bus));
  tdm_demux_1x4 #(.WIDTH(8), .ERRW(2)) u_dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle on both instances, then sample just after the edge.
  task automatic step(input logic vld, input logic sof, input logic [7:0] din);
    @(negedge CLK);
    bus.DIN_VLD = vld;  bus.SOF = sof;  bus.DIN = din;
    bus2.DIN_VLD = vld; bus2.SOF = sof; bus2.DIN = din;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.DIN_VLD = 1'b0;  bus.SOF = 1'b0;
    bus2.DIN_VLD = 1'b0; bus2.SOF = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".F"},      bus.F, 32'h0);
    chk({tag, ".FVLD"},   {28'h0, bus.F_VLD}, 32'h0);
    chk({tag, ".DONE"},   {31'h0, bus.FRAME_DONE}, 32'h0);
    chk({tag, ".LOCKED"}, {31'h0, bus.LOCKED}, 32'h0);
    chk({tag, ".SERR"},   {31'h0, bus.SYNC_ERR}, 32'h0);
    chk({tag, ".ECNT"},   {24'h0, bus.ERR_CNT}, 32'h0);
  endtask

  initial begin
    bus.DIN = '0;  bus.DIN_VLD = 1'b0;  bus.SOF = 1'b0;
    bus2.DIN = '0; bus2.DIN_VLD = 1'b0; bus2.SOF = 1'b0;

    // Reset state
    do_reset();
    chk_all_zero("rst");

    // Two aligned frames
    step(1, 1, 8'h10);
    chk("f1s0.fvld", {28'h0, bus.F_VLD}, 32'h1);
    chk("f1s0.F", bus.F, 32'h0000_0010);
    chk("f1s0.locked", {31'h0, bus.LOCKED}, 32'h1);
    step(1, 0, 8'h11);
    chk("f1s1.fvld", {28'h0, bus.F_VLD}, 32'h2);
    step(1, 0, 8'h12);
    chk("f1s2.fvld", {28'h0, bus.F_VLD}, 32'h4);
    chk("f1s2.done", {31'h0, bus.FRAME_DONE}, 32'h0);
    step(1, 0, 8'h13);
    chk("f1s3.fvld", {28'h0, bus.F_VLD}, 32'h8);
    chk("f1s3.done", {31'h0, bus.FRAME_DONE}, 32'h1);
    chk("f1s3.F", bus.F, 32'h1312_1110);
    step(1, 1, 8'h20);
    chk("f2s0.fvld", {28'h0, bus.F_VLD}, 32'h1);
    chk("f2s0.done", {31'h0, bus.FRAME_DONE}, 32'h0);
    step(1, 0, 8'h21);
    step(1, 0, 8'h22);
    step(1, 0, 8'h23);
    chk("f2s3.done", {31'h0, bus.FRAME_DONE}, 32'h1);
    chk("f2s3.fvld", {28'h0, bus.F_VLD}, 32'h8);
    chk("f2.F", bus.F, 32'h2322_2120);
    chk("f2.serr", {31'h0, bus.SYNC_ERR}, 32'h0);
    chk("f2.ecnt", {24'h0, bus.ERR_CNT}, 32'h0);

    // Words without SOF in HUNT are dropped
    do_reset();
    step(1, 0, 8'hAA);
    chk("hunt.fvld", {28'h0, bus.F_VLD}, 32'h0);
    step(1, 0, 8'hBB);
    chk("hunt.F", bus.F, 32'h0);
    chk("hunt.locked", {31'h0, bus.LOCKED}, 32'h0);
    chk("hunt.serr", {31'h0, bus.SYNC_ERR}, 32'h0);
    step(1, 1, 8'h01);
    chk("acq.locked", {31'h0, bus.LOCKED}, 32'h1);
    chk("acq.F", bus.F, 32'h0000_0001);

    // Gap of 3 idle cycles mid-frame
    do_reset();
    step(1, 1, 8'h80);
    step(1, 0, 8'h81);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'hFF);
      chk("gap.fvld", {28'h0, bus.F_VLD}, 32'h0);
      chk("gap.F", bus.F, 32'h0000_8180);
    end
    step(1, 0, 8'h82);
    chk("gap.s2", {28'h0, bus.F_VLD}, 32'h4);
    chk("gap.s2done", {31'h0, bus.FRAME_DONE}, 32'h0);
    step(1, 0, 8'h83);
    chk("gap.done", {31'h0, bus.FRAME_DONE}, 32'h1);
    chk("gap.F3", bus.F, 32'h8382_8180);

    // Early SOF
    step(1, 1, 8'h30);
    step(1, 0, 8'h31);
    chk("early.pre", bus.F, 32'h8382_3130);
    step(1, 1, 8'h40);
    chk("early.serr", {31'h0, bus.SYNC_ERR}, 32'h1);
    chk("early.fvld", {28'h0, bus.F_VLD}, 32'h1);
    chk("early.F", bus.F, 32'h8382_3140);
    chk("early.ecnt", {24'h0, bus.ERR_CNT}, 32'h1);
    chk("early.locked", {31'h0, bus.LOCKED}, 32'h1);
    chk("early.done", {31'h0, bus.FRAME_DONE}, 32'h0);
    step(0, 0, 8'h00);
    chk("early.serr_pulse", {31'h0, bus.SYNC_ERR}, 32'h0);

    // Finish the resynced frame, then a full frame and a missing SOF
    step(1, 0, 8'h41);
    step(1, 0, 8'h42);
    step(1, 0, 8'h43);
    chk("resync.done", {31'h0, bus.FRAME_DONE}, 32'h1);
    step(1, 1, 8'h50);
    step(1, 0, 8'h51);
    step(1, 0, 8'h52);
    step(1, 0, 8'h53);
    step(1, 0, 8'h60);
    chk("miss.serr", {31'h0, bus.SYNC_ERR}, 32'h1);
    chk("miss.locked", {31'h0, bus.LOCKED}, 32'h0);
    chk("miss.F", bus.F, 32'h5352_5150);
    chk("miss.fvld", {28'h0, bus.F_VLD}, 32'h0);
    chk("miss.ecnt", {24'h0, bus.ERR_CNT}, 32'h2);

    // Reset mid-frame
    step(1, 1, 8'h61);
    step(1, 0, 8'h62);
    step(1, 0, 8'h63);
    chk("mid.pre", bus.F, 32'h5363_6261);
    do_reset();
    chk_all_zero("midrst");
    step(1, 0, 8'h70);
    chk("post.F", bus.F, 32'h0);
    chk("post.locked", {31'h0, bus.LOCKED}, 32'h0);
    chk("post.fvld", {28'h0, bus.F_VLD}, 32'h0);
    chk("post.serr", {31'h0, bus.SYNC_ERR}, 32'h0);

    // Back-to-back SOFs: first locks, next five are early-SOF errors
    step(1, 1, 8'h01);
    step(1, 1, 8'h02);
    step(1, 1, 8'h03);
    step(1, 1, 8'h04);
    chk("sat.e3", {30'h0, bus2.ERR_CNT}, 32'h3);
    step(1, 1, 8'h05);
    chk("sat.e4", {30'h0, bus2.ERR_CNT}, 32'h3);
    chk("sat.serr", {31'h0, bus2.SYNC_ERR}, 32'h1);
    step(1, 1, 8'h06);
    chk("sat.e5", {30'h0, bus2.ERR_CNT}, 32'h3);
    chk("wide.e5", {24'h0, bus.ERR_CNT}, 32'h5);
    chk("sat.F", bus2.F, 32'h0000_0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
